// File: rtl/serial_payload_tx.sv
// UART transmitter for a whole multi-byte payload: capture on start, send MSB byte first, LSB bit first.
// Optional even parity bit after bit 7 when SERIAL_TX_PARITY_EN is defined.
module serial_payload_tx #(
    parameter int COMM_CLK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE          = 115_200,
    parameter int PAYLOAD_BYTES      = 84,
    parameter int STOP_BITS          = 1,
    parameter int GAP_BITS           = 0
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   start,
    input  logic [8*PAYLOAD_BYTES-1:0]             payload,
    input  logic                                   abort,
    output logic                                   txd,
    output logic                                   busy,
    output logic                                   done,
    output logic [$clog2(PAYLOAD_BYTES+1)-1:0]     byte_idx,
    output logic                                   byte_strobe
);

    localparam int DIV  = (COMM_CLK_FREQUENCY + BAUD_RATE / 2) / BAUD_RATE;
    localparam int CNTW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDXW = $clog2(PAYLOAD_BYTES + 1);
    localparam int PW   = 8 * PAYLOAD_BYTES;

    localparam logic [CNTW-1:0] BAUD_LOAD = CNTW'(DIV - 1);
    localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic [3:0]      GAP_LAST  = (GAP_BITS > 0) ? 4'(GAP_BITS - 1) : 4'd0;
    localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(PAYLOAD_BYTES - 1);

    if (DIV < 2) begin : g_bad_div
        $error("serial_payload_tx: bit divider must be at least 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("serial_payload_tx: STOP_BITS must be 1 or 2");
    end
    if (GAP_BITS < 0 || GAP_BITS > 15) begin : g_bad_gap
        $error("serial_payload_tx: GAP_BITS must be 0..15");
    end
    if (PAYLOAD_BYTES < 1 || PAYLOAD_BYTES > 256) begin : g_bad_len
        $error("serial_payload_tx: PAYLOAD_BYTES must be 1..256");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3,
        S_GAP    = 3'd4
`ifdef SERIAL_TX_PARITY_EN
        ,
        S_PARITY = 3'd5
`endif
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [CNTW-1:0]   r_baud_cnt;
    logic [CNTW-1:0]   w_baud_cnt_next;
    logic [3:0]        r_bit_cnt;
    logic [3:0]        w_bit_cnt_next;
    logic [PW-1:0]     r_shadow;
    logic [7:0]        r_tx_byte;
    logic              r_abort;

    logic              r_txd;
    logic              r_busy;
    logic              r_done;
    logic              r_strobe;
    logic [IDXW-1:0]   r_byte_idx;

    logic              w_txd_next;
    logic              w_busy_next;
    logic              w_done_next;
    logic              w_strobe_next;
    logic [IDXW-1:0]   w_byte_idx_next;

    logic              w_bit_end;
    logic              w_last_byte;
    logic              w_abort_any;
    logic              w_accept;
    logic              w_load_next_byte;

    assign w_bit_end   = (r_baud_cnt == '0);
    assign w_last_byte = (r_byte_idx == LAST_IDX);
    // An abort arriving in the very cycle a frame ends still counts.
    assign w_abort_any = r_abort | abort;
    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_load_next_byte = (w_state_next == S_START) &&
                              ((r_state == S_STOP) || (r_state == S_GAP));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_cnt == 4'd7)) begin
`ifdef SERIAL_TX_PARITY_EN
                    w_state_next = S_PARITY;
`else
                    w_state_next = S_STOP;
`endif
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_end && (r_bit_cnt == STOP_LAST)) begin
                    if (w_last_byte || w_abort_any) begin
                        w_state_next = S_IDLE;
                    end else if (GAP_BITS > 0) begin
                        w_state_next = S_GAP;
                    end else begin
                        w_state_next = S_START;
                    end
                end
            end
            S_GAP: begin
                if (w_abort_any) begin
                    w_state_next = S_IDLE;
                end else if (w_bit_end && (r_bit_cnt == GAP_LAST)) begin
                    w_state_next = S_START;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Next values for counters and the registered outputs, all derived from the state transition.
    always_comb begin
        w_baud_cnt_next = r_baud_cnt;
        if (w_state_next == S_IDLE) begin
            w_baud_cnt_next = '0;
        end else if ((r_state == S_IDLE) || w_bit_end) begin
            w_baud_cnt_next = BAUD_LOAD;
        end else begin
            w_baud_cnt_next = r_baud_cnt - CNTW'(1);
        end

        w_bit_cnt_next = r_bit_cnt;
        if ((w_state_next != r_state) || (r_state == S_IDLE)) begin
            w_bit_cnt_next = 4'd0;
        end else if (w_bit_end) begin
            w_bit_cnt_next = r_bit_cnt + 4'd1;
        end

        w_txd_next = 1'b1;
        case (w_state_next)
            S_START:  w_txd_next = 1'b0;
            S_DATA:   w_txd_next = r_tx_byte[w_bit_cnt_next[2:0]];
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: w_txd_next = ^r_tx_byte;
`endif
            default:  w_txd_next = 1'b1;
        endcase

        w_busy_next   = (w_state_next != S_IDLE);
        w_done_next   = (r_state != S_IDLE) && (w_state_next == S_IDLE);
        w_strobe_next = (w_state_next == S_START) && (r_state != S_START);

        w_byte_idx_next = r_byte_idx;
        if (w_accept) begin
            w_byte_idx_next = '0;
        end else if (w_load_next_byte || w_done_next) begin
            w_byte_idx_next = r_byte_idx + IDXW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= 4'd0;
            r_abort    <= 1'b0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_strobe   <= 1'b0;
            r_byte_idx <= '0;
        end else begin
            r_baud_cnt <= w_baud_cnt_next;
            r_bit_cnt  <= w_bit_cnt_next;
            if (r_state == S_IDLE) begin
                r_abort <= 1'b0;
            end else if (abort) begin
                r_abort <= 1'b1;
            end
            r_txd      <= w_txd_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_strobe   <= w_strobe_next;
            r_byte_idx <= w_byte_idx_next;
        end
    end

    // Shadow copy: first byte goes straight to the bit register, the rest queue up MSB-first.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_tx_byte <= payload[PW-1 -: 8];
            r_shadow  <= payload << 8;
        end else if (w_load_next_byte) begin
            r_tx_byte <= r_shadow[PW-1 -: 8];
            r_shadow  <= r_shadow << 8;
        end
    end

    assign txd         = r_txd;
    assign busy        = r_busy;
    assign done        = r_done;
    assign byte_idx    = r_byte_idx;
    assign byte_strobe = r_strobe;

endmodule

// File: doc/serial_payload_tx.md
Name: serial_payload_tx

Overview:
Synthesizable UART transmitter for a whole multi-byte work payload, e.g. the 84-byte getwork image sent to ltcminer_icarus.
- Captures a PAYLOAD_BYTES-wide vector on a start strobe.
- Serialises it byte by byte with configurable framing and inter-byte gap.
- Signals completion with a one-cycle done pulse.
- Replaces word-at-a-time senders that need hand-tuned stop-cycle limits. Used in benches and as the host-link loopback source on the board.

Parameters:
COMM_CLK_FREQUENCY, 100_000_000, clk frequency in Hz
BAUD_RATE, 115_200, serial bit rate
PAYLOAD_BYTES, 84, number of bytes per transfer (1..256)
STOP_BITS, 1, stop bits per frame (1 or 2)
GAP_BITS, 0, idle bit-times inserted between bytes (0..15); none after the last byte

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
start  in  1  begin transfer; sampled only when busy=0
payload  in  8*PAYLOAD_BYTES  data; byte 0 = payload[8*PAYLOAD_BYTES-1 -: 8] is sent first
abort  in  1  stop after the byte currently on the line
txd  out  1  serial output, idle high, registered
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at end of transfer, normal or aborted
byte_idx  out  $clog2(PAYLOAD_BYTES+1)  index of the byte currently being sent; after done, the count of bytes sent
byte_strobe  out  1  one-cycle pulse when each byte's start bit begins

Behaviour:
- Reset values (rstn low, takes effect immediately, no clock needed): txd=1, busy=0, done=0, byte_idx=0, byte_strobe=0. FSM goes to IDLE, abort latch clears.
- Reset mid-frame: txd returns high at once. The partial frame is dropped with no done pulse.
- Bit time: DIV = (COMM_CLK_FREQUENCY + BAUD_RATE/2) / BAUD_RATE, rounded to nearest. DIV < 2 is an elaboration error. Every bit is exactly DIV cycles; down-counter width is $clog2(DIV).
- FSM states: IDLE -> START -> DATA (8 bits, LSB first) -> [PARITY] -> STOP (STOP_BITS) -> GAP (GAP_BITS; skipped when 0 or after the last byte) -> START for the next byte, or IDLE after the last byte.
- Start acceptance: if start=1 and busy=0 at clock edge N:
  - payload is copied into a shadow shift register; later payload changes are ignored.
  - At edge N+1: busy=1, txd=0 (start bit), byte_strobe=1, byte_idx=0.
- start while busy=1 is ignored, with no queuing.
- Frame length F = 1 + 8 + STOP_BITS (+1 if parity is enabled). Total busy time = (PAYLOAD_BYTES*F + (PAYLOAD_BYTES-1)*GAP_BITS) * DIV cycles.
- End of transfer: in the cycle after the last stop bit ends, done=1 and busy=0 together, and byte_idx=PAYLOAD_BYTES.
- A start sampled in the done cycle is accepted, giving back-to-back transfers with no extra idle bit.
- byte_idx increments at each START entry after the first byte.
- Abort:
  - Latched on any cycle while busy. The current frame (including its stop bits) completes, gaps are skipped, then done pulses.
  - byte_idx then equals the number of complete bytes sent.
  - abort while idle has no effect. abort and start in the same idle cycle: start wins and the abort is discarded.
- PAYLOAD_BYTES=1 has no gap phase.

Optional Feature:
Macro SERIAL_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the 8 data bits) follows bit 7, and F grows by 1.
- Undefined: no parity state is generated and F = 9 + STOP_BITS.
- Ports are identical in both builds.

Test Plan:
- COMM_CLK_FREQUENCY=1_000_000, BAUD_RATE=115_200 (DIV=9), PAYLOAD_BYTES=4, payload=32'h000007ff, start pulse -> UART monitor decodes 00,00,07,ff in order; done exactly 360 cycles after the first txd fall; four byte_strobe pulses, 90 cycles apart.
- Same setup with GAP_BITS=2 -> 18 idle-high cycles between frames; done 414 cycles after the first txd fall; no gap after byte 3.
- abort pulsed 100 cycles into the transfer (during byte 1) -> bytes 00,00 sent complete; done at cycle 180; byte_idx=2; txd high afterwards.
- start re-pulsed mid-transfer with a different payload, and payload changed after acceptance -> output unchanged (00,00,07,ff); start asserted in the done cycle -> second transfer's start bit on the next edge.
- rstn dropped mid-data-bit -> txd=1 and busy=0 immediately, no done; a new start after release sends a clean full transfer.
- SERIAL_TX_PARITY_EN defined, payload byte 8'h07 -> parity bit 1; byte 8'hff -> parity bit 0; done at 4*11*9 = 396 cycles.
